// File: rtl/matrix_pkg.sv
// Shared types and default sizes for the matrix store/load blocks.
// Optional checksum output is enabled by defining MATRIX_STORE_CHECKSUM_EN.
package matrix_pkg;
    localparam int DEF_DIM    = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = $clog2(DEF_DIM * DEF_DIM);

    typedef logic [DEF_DATA_W-1:0] elem_t;
    typedef elem_t [0:DEF_DIM-1][0:DEF_DIM-1] matrix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } store_state_e;
endpackage

// File: rtl/matrix_ram.sv
// DIM*DIM x DATA_W RAM: one synchronous write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module matrix_ram #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately left unreset so a reset mid-store keeps partial data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/matrix_store.sv
// Snapshots a DIM x DIM matrix on start and writes it row-major into matrix_ram.
// Defining MATRIX_STORE_CHECKSUM_EN adds a running sum of the written elements.
module matrix_store
    import matrix_pkg::*;
#(
    parameter  int DIM    = DEF_DIM,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int ADDR_W = $clog2(DIM * DIM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DATA_W-1:0]        matrix [0:DIM-1][0:DIM-1],
    output logic                     busy,
    output logic                     done,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output store_state_e             dbg_state
`ifdef MATRIX_STORE_CHECKSUM_EN
    ,
    output logic [DATA_W+ADDR_W-1:0] checksum
`endif
);
    localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM - 1);

    store_state_e      r_state;
    logic [CNT_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_col;
    logic              r_busy;
    logic              r_done;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_shadow [0:DIM-1][0:DIM-1];

    logic              w_last;
    logic              w_accept;
    logic [CNT_W-1:0]  w_next_row;
    logic [CNT_W-1:0]  w_next_col;
    logic [ADDR_W-1:0] w_next_addr;

    // start is a level request with no acknowledge: it is accepted only in IDLE,
    // requests seen in WRITE/DONE are dropped, and a held start re-fires every IDLE cycle.
    assign w_accept = (r_state == IDLE) && start;

    always_comb begin
        w_last     = (r_row == LAST_IDX) && (r_col == LAST_IDX);
        w_next_row = r_row;
        w_next_col = r_col + CNT_W'(1);
        if (r_col == LAST_IDX) begin
            w_next_col = '0;
            w_next_row = r_row + CNT_W'(1);
        end
        w_next_addr = ADDR_W'(int'(w_next_row) * DIM + int'(w_next_col));
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow <= matrix;
        end
    end

`ifdef MATRIX_STORE_CHECKSUM_EN
    logic [DATA_W+ADDR_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (r_wr_en) begin
            r_checksum <= r_checksum + (DATA_W+ADDR_W)'(r_wr_data);
        end
    end

    assign checksum = r_checksum;
`endif

    // wr_* are loaded one cycle ahead so each element is on the port during its write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= WRITE;
                        r_busy    <= 1'b1;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= matrix[0][0];
                    end
                end
                WRITE: begin
                    if (w_last) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_wr_en   <= 1'b0;
                        r_wr_addr <= '0;
                        r_wr_data <= '0;
                    end else begin
                        r_row     <= w_next_row;
                        r_col     <= w_next_col;
                        r_wr_addr <= w_next_addr;
                        r_wr_data <= r_shadow[w_next_row][w_next_col];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_row   <= '0;
                    r_col   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    matrix_ram #(
        .DEPTH  (DIM * DIM),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (r_wr_en),
        .i_waddr (r_wr_addr),
        .i_wdata (r_wr_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_matrix_store.sv
// Directed bench for matrix_store: write sequence, latency, snapshot, restart,
// mid-store reset, read-before-write and (with MATRIX_STORE_CHECKSUM_EN) the checksum.
module tb_matrix_store;
    import matrix_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   mat [0:7][0:7];
    logic         busy;
    logic         done;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [7:0]   wr_data;
    logic [5:0]   rd_addr = '0;
    logic [7:0]   rd_data;
    store_state_e dbg_state;
`ifdef MATRIX_STORE_CHECKSUM_EN
    logic [13:0]  checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matrix_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .matrix    (mat),
        .busy      (busy),
        .done      (done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .dbg_state (dbg_state)
`ifdef MATRIX_STORE_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // 0: r*8+c, 1: (r*8+c)^C0, 2: r*8+c+40, 3: all FF, 4: all zero
    task automatic set_pattern(input int mode);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (mode)
                    0: mat[r][c] = 8'(r * 8 + c);
                    1: mat[r][c] = 8'(r * 8 + c) ^ 8'hC0;
                    2: mat[r][c] = 8'(r * 8 + c + 8'h40);
                    3: mat[r][c] = 8'hFF;
                    default: mat[r][c] = 8'h00;
                endcase
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the first write cycle.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy === 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b still set after %0d cycles", busy, t);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_pattern(4);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, wr_en} !== 3'b000 || wr_addr !== 6'd0 || wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b wr_en=%b addr=%0d data=%0h, expected all 0",
                     busy, done, wr_en, wr_addr, wr_data);
        end
        n_checks++;
        if (rd_data !== 8'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: rd_data=%0h state=%0d, expected 0 / IDLE", rd_data, dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_pattern(0);
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 6'(i) || wr_data !== 8'(i) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_write[%0d]: wr_en=%b addr=%0d data=%0h done=%b, expected 1/%0d/%0h/0",
                         i, wr_en, wr_addr, wr_data, done, i, i);
            end
            if (i < 63) @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_latency: done=%b busy=%b wr_en=%b, expected 1/1/0", done, busy, wr_en);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL basic_after_done: done=%b busy=%b state=%0d, expected 0/0/IDLE", done, busy, dbg_state);
        end
        rd_addr = 6'd37;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h25) begin
            n_fail++;
            $display("FAIL basic_read37: rd_data=%0h expected 25", rd_data);
        end
    endtask

    task automatic test_read_before_write();
        set_pattern(0);
        mat[1][2] = 8'hAB;
        pulse_start();
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_addr !== 6'd10 || wr_data !== 8'hAB) begin
            n_fail++;
            $display("FAIL rbw_write: addr=%0d data=%0h, expected 10/ab", wr_addr, wr_data);
        end
        rd_addr = 6'd10;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h0A) begin
            n_fail++;
            $display("FAIL rbw_old: rd_data=%0h expected 0a", rd_data);
        end
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'hAB) begin
            n_fail++;
            $display("FAIL rbw_new: rd_data=%0h expected ab", rd_data);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int writes = 0;
        int dones = 0;
        int done_t1 = 0;
        int done_t2 = 0;
        int data_err = 0;
        set_pattern(1);
        start = 1'b1;
        for (int t = 1; t <= 131; t++) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                writes++;
                if (wr_data !== (8'(wr_addr) ^ 8'hC0)) data_err++;
            end
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) done_t1 = t;
                else done_t2 = t;
            end
            if (t == 66) begin
                n_checks++;
                if (wr_en !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle_gap: wr_en=%b busy=%b, expected 0/0", wr_en, busy);
                end
            end
            if (t == 67) begin
                n_checks++;
                if (wr_en !== 1'b1 || wr_addr !== 6'd0) begin
                    n_fail++;
                    $display("FAIL b2b_restart: wr_en=%b addr=%0d, expected 1/0", wr_en, wr_addr);
                end
            end
            if (t == 131) start = 1'b0;
        end
        n_checks++;
        if (writes != 128 || data_err != 0) begin
            n_fail++;
            $display("FAIL b2b_writes: writes=%0d data_errors=%0d, expected 128/0", writes, data_err);
        end
        n_checks++;
        if (dones != 2 || done_t1 != 65 || done_t2 != 131) begin
            n_fail++;
            $display("FAIL b2b_done: count=%0d at %0d,%0d, expected 2 at 65,131", dones, done_t1, done_t2);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop: busy=%b wr_en=%b, expected 0/0", busy, wr_en);
        end
    endtask

    task automatic test_snapshot();
        int writes = 0;
        int dones = 0;
        int done_t = 0;
        set_pattern(0);
        pulse_start();
        for (int t = 1; t <= 70; t++) begin
            if (wr_en === 1'b1) writes++;
            if (done === 1'b1) begin
                dones++;
                done_t = t;
            end
            if (t == 2) set_pattern(3);
            start = (t == 5 || t == 30);
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (writes != 64 || dones != 1 || done_t != 65) begin
            n_fail++;
            $display("FAIL snap_stray_start: writes=%0d dones=%0d done_at=%0d, expected 64/1/65",
                     writes, dones, done_t);
        end
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            @(negedge clk);
            n_checks++;
            if (rd_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL snap_mem[%0d]: rd_data=%0h expected %0h", i, rd_data, i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        set_pattern(2);
        pulse_start();
        repeat (20) @(negedge clk);
        n_checks++;
        if (wr_addr !== 6'd20 || wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pos: addr=%0d wr_en=%b, expected 20/1", wr_addr, wr_en);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, wr_en} !== 3'b000 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL rstmid_async: busy=%b done=%b wr_en=%b state=%0d, expected 0/0/0/IDLE",
                     busy, done, wr_en, dbg_state);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            if (done !== 1'b0 || wr_en !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: %0d cycles with done/wr_en set, expected 0", bad);
        end
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            @(negedge clk);
            n_checks++;
            if (rd_data !== ((i < 20) ? 8'(i + 8'h40) : 8'(i))) begin
                n_fail++;
                $display("FAIL rstmid_mem[%0d]: rd_data=%0h expected %0h",
                         i, rd_data, (i < 20) ? (i + 8'h40) : i);
            end
        end
    endtask

`ifdef MATRIX_STORE_CHECKSUM_EN
    task automatic test_checksum();
        set_pattern(3);
        pulse_start();
        repeat (64) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || checksum !== 14'h3FC0) begin
            n_fail++;
            $display("FAIL checksum_ff: done=%b checksum=%0h, expected 1/3fc0", done, checksum);
        end
        @(negedge clk);
        set_pattern(4);
        pulse_start();
        repeat (64) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || checksum !== 14'h0000) begin
            n_fail++;
            $display("FAIL checksum_zero: done=%b checksum=%0h, expected 1/0", done, checksum);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_read_before_write();
        test_back_to_back();
        test_snapshot();
        test_reset_mid();
`ifdef MATRIX_STORE_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_store.md
Name: matrix_store

Overview:
- Write-back counterpart to the matrix loader. Takes a parallel DIM x DIM result matrix, snapshots it on a start request, and serializes it row-major into an internal DIM*DIM-entry memory, one element per cycle.
- Exposes the write stream for observation, a registered read port for downstream consumers and benches, and busy/done status.

Parameters:
- DIM, 8, matrix dimension (rows = cols).
- DATA_W, 8, element width in bits.
- ADDR_W, $clog2(DIM*DIM) = 6, memory address width (derived; not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to store the current matrix; sampled only in IDLE.
- matrix  input  DIM x DIM x DATA_W  unpacked [0:DIM-1][0:DIM-1] array of DATA_W-bit elements to store.
- busy  output  1  high in WRITE and DONE.
- done  output  1  one-cycle pulse after the last element is written.
- wr_en  output  1  high on each cycle an element is written.
- wr_addr  output  ADDR_W  address being written (row*DIM+col).
- wr_data  output  DATA_W  element being written.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  registered read data, 1-cycle latency.

Behaviour:
- Reset values: state=IDLE; busy, done and wr_en = 0; wr_addr and wr_data = 0; rd_data = 0; row/col counters = 0. Memory contents are not reset.
- States:
  - IDLE: start=1 -> snapshot the full matrix into a shadow register; clear counters; go to WRITE.
  - WRITE: each cycle write shadow[row][col] to mem[row*DIM+col] and drive wr_en=1, wr_addr and wr_data with the same values. col increments; at col=DIM-1, col wraps to 0 and row increments. When the write at address DIM*DIM-1 occurs, go to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Latency: start sampled at edge k -> writes on cycles k+1 .. k+DIM*DIM -> done on cycle k+DIM*DIM+1. For DIM=8, done is 65 cycles after start.
- Changes on the matrix input after the snapshot edge have no effect on the current store.
- start during WRITE or DONE is ignored and not queued. A start held high re-triggers on the first IDLE cycle.
- Read port:
  - Read-before-write: a read of an address written in the same cycle returns the old contents.
  - Reads are legal in any state; rd_addr values >= DIM*DIM are impossible at the default DIM.
- Reset mid-operation: return to IDLE immediately, no done pulse. Memory keeps any partial writes.
- Counter widths are $clog2(DIM) bits each; the address is computed without truncation.

Optional Feature:
- Macro: MATRIX_STORE_CHECKSUM_EN
- With the macro defined:
  - Adds output checksum [DATA_W+ADDR_W-1:0]: the unsigned sum of all written elements.
  - Cleared when start is accepted; accumulates each wr_en cycle.
  - Stable and valid from the done cycle until the next accepted start. Reset value 0.
- Without the macro: the port and the accumulator are absent.

Decomposition:
- Shared package matrix_pkg:
  - DIM and DATA_W defaults, ADDR_W.
  - Element typedef elem_t (logic [DATA_W-1:0]) and matrix_t (elem_t [0:DIM-1][0:DIM-1]).
  - State enum store_state_e {IDLE, WRITE, DONE}.
- One sub-module: matrix_ram, a single-port-write / single-port-read synchronous RAM, DIM*DIM x DATA_W, read-before-write. The FSM, counters and snapshot live in matrix_store.

Test Plan:
- Reset, then matrix[r][c] = r*8+c, pulse start -> wr_addr sequence 0..63 with wr_data = wr_addr; done exactly 65 cycles after start; rd_addr 37 -> rd_data 0x25 one cycle later.
- After start, overwrite the matrix input with 0xFF everywhere during WRITE -> memory still holds r*8+c.
- Hold start high continuously -> second store begins the cycle after done; start pulses during WRITE produce no extra writes.
- Deassert rst_n at write 20 -> busy, done and wr_en go low asynchronously; mem[0..19] hold new data, mem[20..63] hold old data; no done pulse.
- Read address 10 on the same cycle it is written with 0xAB (old value 0x0A) -> rd_data = 0x0A, and 0xAB on the next read.
- With MATRIX_STORE_CHECKSUM_EN, matrix all 0xFF -> checksum = 64*255 = 16320 (0x3FC0) at done; all-zero matrix -> 0.
